// File: rtl/exponent_align_phase.sv
// ---------------------------------------------------------------------------
// exponent_align_phase
//
// Second stage of the floating-point add/subtract datapath. Takes the
// larger-magnitude operand (DMP) and smaller-magnitude operand (DmP) from
// the compare/swap stage, computes the exponent difference and right-shifts
// the smaller significand into alignment with the larger one, collecting
// guard/round/sticky bits on the way. Results go to the significand adder.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-low (rst=0 resets)
//   start     one-cycle request; DMP/DmP are sampled on that edge when idle
//   DMP       larger-magnitude operand (IEEE 754, W bits)
//   DmP       smaller-magnitude operand (IEEE 754, W bits)
//   busy      high whenever the block is not idle
//   done      one-cycle pulse; outputs are valid from this cycle on
//   Exp_out   common exponent (effective exponent of DMP)
//   Sign_out  sign of DMP
//   eff_sub   effective subtraction flag (sign(DMP) ^ sign(DmP))
//   Mant_M    {hidden, mantissa, 3'b000} of DMP
//   Mant_m    aligned {hidden, mantissa, G, R, S} of DmP
//
// Build option:
//   ALIGN_BARREL_EN  when defined, the alignment shift is done in a single
//                    cycle by a barrel shifter (fixed latency). When left
//                    undefined, an iterative 1-bit-per-cycle shifter is
//                    used. Output values are identical in both builds.
// ---------------------------------------------------------------------------
module exponent_align_phase #(
  parameter  int W  = 32,
  localparam int EW = (W == 64) ? 11 : 8,
  localparam int MW = W - EW - 1,
  localparam int SW = MW + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  DMP,
  input  logic [W-1:0]  DmP,
  output logic          busy,
  output logic          done,
  output logic [EW-1:0] Exp_out,
  output logic          Sign_out,
  output logic          eff_sub,
  output logic [SW-1:0] Mant_M,
  output logic [SW-1:0] Mant_m
);

  localparam int             CW   = $clog2(SW + 1);
  localparam logic [EW:0]    SW_D = (EW + 1)'(SW);
  localparam logic [CW-1:0]  SW_C = CW'(SW);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [W-1:0]  op_big;
  logic [W-1:0]  op_small;
  logic [CW-1:0] count;

  logic [EW-1:0] exp_big;
  logic [EW-1:0] exp_small;
  logic [EW-1:0] eff_big;
  logic [EW-1:0] eff_small;
  logic          hid_big;
  logic          hid_small;
  logic [EW:0]   diff;
  logic [CW-1:0] count_calc;

  // Field decode of the captured operands. A zero exponent field marks a
  // denormal: no hidden bit, and it behaves as if its exponent were 1.
  assign exp_big   = op_big[W-2:MW];
  assign exp_small = op_small[W-2:MW];
  assign hid_big   = |exp_big;
  assign hid_small = |exp_small;
  assign eff_big   = hid_big   ? exp_big   : EW'(1);
  assign eff_small = hid_small ? exp_small : EW'(1);

  // The difference is never negative because the upstream stage already
  // ordered the operands; the extra bit only keeps the subtraction exact.
  // Shifting beyond SW positions changes nothing once everything has
  // collapsed into the sticky bit, so the count saturates there.
  assign diff       = {1'b0, eff_big} - {1'b0, eff_small};
  assign count_calc = (diff >= SW_D) ? SW_C : diff[CW-1:0];

`ifdef ALIGN_BARREL_EN
  logic [SW-1:0] lost_mask;
  logic [SW-1:0] barrel_out;

  // Single-step equivalent of the iterative shifter: every bit shifted out
  // is OR-ed into the LSB. A shift by SW yields an all-ones mask, so the
  // whole significand folds into sticky.
  assign lost_mask  = ~({SW{1'b1}} << count);
  assign barrel_out = (Mant_m >> count) | {{(SW-1){1'b0}}, |(Mant_m & lost_mask)};
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A start seen outside IDLE (including the DONE cycle)
  // is simply dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = CALC;
      CALC:  next_state = SHIFT;
`ifdef ALIGN_BARREL_EN
      SHIFT: next_state = DONE;
`else
      SHIFT: if (count == '0) next_state = DONE;
`endif
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers. Operands are captured on the accepting edge, all
  // results are loaded in CALC, and only the small significand moves during
  // SHIFT. Everything holds afterwards until the next CALC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_big   <= '0;
      op_small <= '0;
      count    <= '0;
      Exp_out  <= '0;
      Sign_out <= 1'b0;
      eff_sub  <= 1'b0;
      Mant_M   <= '0;
      Mant_m   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_big   <= DMP;
            op_small <= DmP;
          end
        end
        CALC: begin
          Exp_out  <= eff_big;
          Sign_out <= op_big[W-1];
          eff_sub  <= op_big[W-1] ^ op_small[W-1];
          Mant_M   <= {hid_big,   op_big[MW-1:0],   3'b000};
          Mant_m   <= {hid_small, op_small[MW-1:0], 3'b000};
          count    <= count_calc;
        end
        SHIFT: begin
`ifdef ALIGN_BARREL_EN
          Mant_m <= barrel_out;
          count  <= '0;
`else
          // Bit 0 acts as sticky: bits 1 and 0 merge into it each step.
          if (count != '0) begin
            Mant_m <= {1'b0, Mant_m[SW-1:2], Mant_m[1] | Mant_m[0]};
            count  <= count - CW'(1);
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exponent_align_phase.sv
// ---------------------------------------------------------------------------
// tb_exponent_align_phase
//
// Self-checking bench for exponent_align_phase at W=32. Expected values come
// from an arithmetic reference model: the small significand is treated as
// an integer, divided by 2^n, and any non-zero remainder sets the LSB.
// ---------------------------------------------------------------------------
module tb_exponent_align_phase;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] DMP;
  logic [31:0] DmP;
  logic        busy;
  logic        done;
  logic [7:0]  Exp_out;
  logic        Sign_out;
  logic        eff_sub;
  logic [26:0] Mant_M;
  logic [26:0] Mant_m;

  int checks = 0;
  int errors = 0;

  exponent_align_phase #(.W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .DMP      (DMP),
    .DmP      (DmP),
    .busy     (busy),
    .done     (done),
    .Exp_out  (Exp_out),
    .Sign_out (Sign_out),
    .eff_sub  (eff_sub),
    .Mant_M   (Mant_M),
    .Mant_m   (Mant_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: exact integer alignment with a sticky remainder.
  task automatic refModel(input logic [31:0] a, input logic [31:0] b,
                          output logic [7:0] e, output logic [26:0] mM,
                          output logic [26:0] mm, output logic s,
                          output logic sub, output int lat);
    longint ea, eb, effA, effB, sigA, sigB, n, fullB, kept, lost;
    ea   = longint'(a[30:23]);
    eb   = longint'(b[30:23]);
    effA = (ea == 0) ? 1 : ea;
    effB = (eb == 0) ? 1 : eb;
    sigA = ((ea != 0) ? 64'd8388608 : 64'd0) + longint'(a[22:0]);
    sigB = ((eb != 0) ? 64'd8388608 : 64'd0) + longint'(b[22:0]);
    n    = effA - effB;
    if (n > 27) n = 27;
    fullB = sigB * 8;
    kept  = fullB / (64'd1 << n);
    lost  = fullB - kept * (64'd1 << n);
    e   = 8'(effA);
    mM  = 27'(sigA * 8);
    mm  = 27'(kept | ((lost != 0) ? 64'd1 : 64'd0));
    s   = a[31];
    sub = a[31] ^ b[31];
`ifdef ALIGN_BARREL_EN
    lat = 3;
`else
    lat = int'(n) + 3;
`endif
  endtask

  // Drive one start pulse; returns right after the sampling edge (edge 0).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    DMP   = a;
    DmP   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full operation with checks. If repulseCycle > 0, a second start with
  // other operands is driven in that cycle while busy and must be ignored.
  task automatic runOp(input string name, input logic [31:0] a,
                       input logic [31:0] b, input int repulseCycle,
                       input logic [31:0] ra, input logic [31:0] rb);
    logic [7:0]  eExp;
    logic [26:0] eMM, eMm;
    logic        eS, eSub;
    int          eLat;
    int          cyc;
    logic        got;
    refModel(a, b, eExp, eMM, eMm, eS, eSub, eLat);
    applyStimulus(a, b);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput({name, "_busy"}, 64'(busy), 64'd1);
      if (done) begin
        got = 1'b1;
      end else if (cyc == repulseCycle) begin
        DMP   = ra;
        DmP   = rb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    checkOutput({name, "_done_seen"}, 64'(got), 64'd1);
    checkOutput({name, "_latency"}, 64'(cyc), 64'(eLat));
    checkOutput({name, "_Exp_out"}, 64'(Exp_out), 64'(eExp));
    checkOutput({name, "_Mant_M"}, 64'(Mant_M), 64'(eMM));
    checkOutput({name, "_Mant_m"}, 64'(Mant_m), 64'(eMm));
    checkOutput({name, "_Sign_out"}, 64'(Sign_out), 64'(eS));
    checkOutput({name, "_eff_sub"}, 64'(eff_sub), 64'(eSub));
    @(negedge clk);
    checkOutput({name, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({name, "_idle_after"}, 64'(busy), 64'd0);
    checkOutput({name, "_hold_Mant_m"}, 64'(Mant_m), 64'(eMm));
  endtask

  // Random operand pair with effexp(a) >= effexp(b).
  task automatic randomPair(output logic [31:0] a, output logic [31:0] b);
    int expA, expB, d;
    expA = int'($urandom_range(0, 254));
    d    = int'($urandom_range(0, 40));
    expB = (expA > d) ? expA - d : 0;
    a = {1'($urandom), 8'(expA), 23'($urandom)};
    b = {1'($urandom), 8'(expB), 23'($urandom)};
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          cyc;
    rst   = 1'b0;
    start = 1'b0;
    DMP   = '0;
    DmP   = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_Mant_M", 64'(Mant_M), 64'd0);
    checkOutput("rst_Mant_m", 64'(Mant_m), 64'd0);
    checkOutput("rst_Exp_out", 64'(Exp_out), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start", 64'(busy), 64'd0);

    // Directed cases.
    runOp("t_diff1", 32'h40400000, 32'h3F800000, 0, 0, 0);
    runOp("t_diff4", 32'h41800000, 32'h3F800001, 0, 0, 0);
    runOp("t_sat",   32'h4B800000, 32'h33800001, 0, 0, 0);
    runOp("t_denorm", 32'h00800000, 32'h00000001, 0, 0, 0);
    runOp("t_sign",  32'hC0400000, 32'h3F800000, 0, 0, 0);

    // Start re-pulsed while busy must not disturb the captured operands.
    runOp("t_repulse", 32'h41800000, 32'h3F800001, 2, 32'hC2000000, 32'h00000005);

    // Start during the DONE cycle is dropped.
    applyStimulus(32'h40400000, 32'h3F800000);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("donecyc_seen", 64'(done), 64'd1);
    DMP   = 32'h4B800000;
    DmP   = 32'h33800001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("donecyc_ignored", 64'(busy), 64'd0);
    checkOutput("donecyc_Mant_M", 64'(Mant_M), 64'h6000000);

    // Reset in the middle of the shift phase.
    applyStimulus(32'h4B800000, 32'h33800001);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_Mant_M", 64'(Mant_M), 64'd0);
    checkOutput("midrst_Mant_m", 64'(Mant_m), 64'd0);
    checkOutput("midrst_Exp_out", 64'(Exp_out), 64'd0);
    checkOutput("midrst_Sign_out", 64'(Sign_out), 64'd0);
    checkOutput("midrst_eff_sub", 64'(eff_sub), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_done", 64'(done), 64'd0);
    end
    runOp("t_after_rst", 32'h41800000, 32'h3F800001, 0, 0, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 25; i++) begin
      randomPair(ra, rb);
      runOp($sformatf("rnd%0d", i), ra, rb, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
